// File: rtl/noise_sh.sv
// -----------------------------------------------------------------------------
// noise_sh -- sample-and-hold noise shaper with a shift-based one-pole lowpass.
//
// On each sample-rate tick (ena) the block counts toward a programmable hold
// period. When the period expires it captures a fresh noise word into `held`.
// In the following cycle the output `y` slews toward `held` by
// (held - y) >>> smooth, and out_valid pulses for one cycle.
//
// Ports:
//   clk        in   1      system clock
//   rst        in   1      asynchronous, active-high reset
//   ena        in   1      sample-rate tick, one cycle wide
//   noise_in   in   WIDTH  raw LFSR bits, treated as two's-complement signed
//   rate       in   DIVW   hold period minus 1, in ena ticks (0 = every tick)
//   smooth     in   4      lowpass shift k (0 = no smoothing)
//   out        out  WIDTH  shaped noise (signed), equal to internal y
//   out_valid  out  1      one-cycle pulse when out has been updated
//   dbg_state  out  1      FSM state (0 = IDLE, 1 = FILT) for checkers
//
// Handshake: ena is a strobe with no back-pressure. It is honoured only in
// IDLE; an ena that lands in FILT is dropped entirely, so upstream spaces ena
// at least 2 cycles apart. out_valid is a strobe with no ready.
// -----------------------------------------------------------------------------
module noise_sh #(
  parameter int WIDTH = 18,
  parameter int DIVW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] noise_in,
  input  logic [DIVW-1:0]  rate,
  input  logic [3:0]       smooth,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    FILT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [DIVW-1:0]  cnt_q,   cnt_d;
  logic [WIDTH-1:0] held_q,  held_d;
  logic [WIDTH-1:0] y_q,     y_d;
  logic             vld_q,   vld_d;

  // One extra bit so held - y never overflows.
  logic signed [WIDTH:0] diff;
  logic signed [WIDTH:0] diff_sh;
  logic [WIDTH-1:0]      y_step;

  assign diff    = $signed({held_q[WIDTH-1], held_q}) - $signed({y_q[WIDTH-1], y_q});
  // Arithmetic shift floors toward -inf. The step magnitude never exceeds
  // |held - y|, so y stays between its old value and held and the WIDTH-bit
  // truncation of the sum is exact.
  assign diff_sh = diff >>> smooth;
  assign y_step  = y_q + WIDTH'(diff_sh);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    y_d     = y_q;
    vld_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ena) begin
          // >= so that lowering rate below the current count captures on the
          // next tick rather than waiting for the counter to wrap.
          if (cnt_q >= rate) begin
            held_d = noise_in;
            cnt_d  = '0;
          end else begin
            cnt_d  = cnt_q + {{(DIVW-1){1'b0}}, 1'b1};
          end
          state_d = FILT;
        end
      end
      FILT: begin
        y_d     = y_step;
        vld_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      held_q  <= '0;
      y_q     <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      y_q     <= y_d;
      vld_q   <= vld_d;
    end
  end

  assign out       = y_q;
  assign out_valid = vld_q;
  assign dbg_state = state_q;

endmodule
